pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline: fetch, decode, execute, memory, writeback.
- Each cycle it drives the PC enable and the enable/flush pair of every inter-stage latch (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Resolves instruction-memory misses, data-memory waits, load-use hazards, taken branches, jumps and halt drain.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- DRAIN_CYC, 3, number of stage advances from a halt in decode until the halt reaches writeback.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- nRST  in  1  reset, synchronous and active-low.
- ihit  in  1  instruction fetch valid this cycle.
- dhit  in  1  data memory access complete this cycle.
- mem_dREN  in  1  memory-stage instruction reads data memory.
- mem_dWEN  in  1  memory-stage instruction writes data memory.
- ex_dREN  in  1  execute-stage instruction is a load.
- ex_wsel  in  5  execute-stage destination register.
- de_rs  in  5  decode-stage rs.
- de_rt  in  5  decode-stage rt.
- de_uses_rt  in  1  decode-stage instruction reads rt.
- de_jump  in  1  decode-stage jump (J/JAL/JR).
- de_halt  in  1  decode-stage opcode is halt.
- ex_branch_taken  in  1  execute-stage branch resolved taken.
- pc_en  out  1  PC may update.
- fd_en, de_en, em_en, mw_en  out  1 each  latch load enables.
- fd_flush, de_flush, em_flush, mw_flush  out  1 each  latch clear, inserting a bubble.
- halt_out  out  1  pipeline fully drained and halted.
- stall_cnt  out  CNT_W  cycles in which pc_en=0 while in RUN or DRAIN.
- flush_cnt  out  CNT_W  cycles in which fd_flush was caused by a branch or jump.

Behaviour:
- Latch rule, implemented by the stage latches: flush wins over enable; otherwise enable loads the latch; otherwise the latch holds.
- While nRST=0 at a clock edge:
  - state goes to RUN, drain counter to 0, both counters to 0.
  - Outputs are combinational and forced while nRST=0: all en=0, all flush=1, pc_en=0, halt_out=0.
- States: RUN, DRAIN, HALTED.
- RUN output priority (highest wins; default is all en=1, all flush=0, pc_en=1):
  1. dwait = (mem_dREN|mem_dWEN)&~dhit. pc_en=fd_en=de_en=em_en=0; mw_flush=1. Nothing else applies.
  2. ex_branch_taken. pc_en=1, fd_flush=1, de_flush=1. This overrides load-use, jump and halt, because those instructions are on the wrong path.
  3. load-use = ex_dREN & ex_wsel!=0 & (ex_wsel==de_rs | (de_uses_rt & ex_wsel==de_rt)). pc_en=fd_en=0, de_flush=1; em and mw advance.
  4. de_jump. pc_en=1, fd_flush=1 (one bubble).
  5. ~ihit. pc_en=0, fd_flush=1; downstream stages advance.
- RUN to DRAIN: when de_halt & ~dwait & ~ex_branch_taken & ~load-use. The halt advances into execute that cycle; drain counter loads DRAIN_CYC-1.
- DRAIN:
  - pc_en=0 and fd_flush=1 every cycle.
  - dwait rule applies as in RUN.
  - Otherwise de, em and mw advance and the drain counter decrements.
  - Counter already 0 on an advancing cycle goes to HALTED.
  - Branch and jump inputs are ignored, since only older instructions are in flight.
- HALTED: all en=0, all flush=0, pc_en=0, halt_out=1. Only reset leaves this state.
- halt_out is registered: it asserts on the first cycle in HALTED, with no combinational path from inputs.
- Counters:
  - Each increments by 1 per qualifying cycle.
  - Each saturates at all-ones with no wrap.
  - Neither changes in HALTED.
- Simultaneous events:
  - dwait with branch: branch is held, not lost. Execute is frozen, so ex_branch_taken stays asserted next cycle.
  - dwait with ~ihit: dwait rule only.
- Latency: all outputs are combinational from current state and inputs, and take effect at the next edge. No output depends on a previous-cycle input except through state.

Test Plan:
- Reset held 2 cycles, release with ihit=1 and no hazards -> pc_en and all en=1, all flush=0, counters 0, halt_out=0.
- ex_dREN=1, ex_wsel=5, de_rs=5, ihit=1 for 1 cycle -> pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1; stall_cnt goes 0 to 1. Repeat with ex_wsel=0 -> no stall.
- mem_dREN=1, dhit=0 for 4 cycles, then dhit=1 -> 4 cycles of pc/fd/de/em en=0 with mw_flush=1, normal flow on the dhit cycle; stall_cnt=4.
- ex_branch_taken=1 with a load-use match and de_halt=1 in the same cycle -> fd_flush=de_flush=1, pc_en=1, state stays RUN, flush_cnt=1.
- de_halt=1 with no hazards, then inject one dwait cycle during DRAIN -> halt_out rises exactly DRAIN_CYC+1 advancing cycles after the halt cycle (5 cycles total with the wait). halt_out stays 1 and counters freeze until reset.
- Force stall_cnt near saturation using CNT_W=4 and 20 stall cycles -> value holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline, with halt drain
// and saturating stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       de_rs,
  input  logic [4:0]       de_rt,
  input  logic             de_uses_rt,
  input  logic             de_jump,
  input  logic             de_halt,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             em_flush,
  output logic             mw_flush,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]    state, next_state;
  logic [DW-1:0] drain_cnt, next_drain;
  logic          dwait, load_use, ctl_flush;

  assign dwait    = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use = ex_dREN & (ex_wsel != 5'd0) &
                    ((ex_wsel == de_rs) | (de_uses_rt & (ex_wsel == de_rt)));

  always_comb begin
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    de_en      = 1'b1;
    em_en      = 1'b1;
    mw_en      = 1'b1;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    em_flush   = 1'b0;
    mw_flush   = 1'b0;
    ctl_flush  = 1'b0;
    next_state = state;
    next_drain = drain_cnt;

    case (state)
      RUN: begin
        if (dwait) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_en    = 1'b0;
          em_en    = 1'b0;
          mw_flush = 1'b1;
        end else if (ex_branch_taken) begin
          fd_flush  = 1'b1;
          de_flush  = 1'b1;
          ctl_flush = 1'b1;
        end else if (load_use) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_flush = 1'b1;
        end else if (de_jump) begin
          fd_flush  = 1'b1;
          ctl_flush = 1'b1;
        end else if (!ihit) begin
          pc_en    = 1'b0;
          fd_flush = 1'b1;
        end
        // The halt only counts once it actually moves into execute.
        if (de_halt && !dwait && !ex_branch_taken && !load_use) begin
          next_state = DRAIN;
          next_drain = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        pc_en    = 1'b0;
        fd_flush = 1'b1;
        if (dwait) begin
          fd_en    = 1'b0;
          de_en    = 1'b0;
          em_en    = 1'b0;
          mw_flush = 1'b1;
        end else if (drain_cnt == '0) begin
          next_state = HALTED;
        end else begin
          next_drain = drain_cnt - DW'(1);
        end
      end
      default: begin
        pc_en = 1'b0;
        fd_en = 1'b0;
        de_en = 1'b0;
        em_en = 1'b0;
        mw_en = 1'b0;
      end
    endcase

    if (!nRST) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      em_en    = 1'b0;
      mw_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
      mw_flush = 1'b1;
    end
  end

  assign halt_out = nRST & (state == HALTED);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain;
      if ((state != HALTED) && !pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == RUN) && ctl_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
